// File: rtl/reg_sel_decoder.sv
// Registered one-hot register-select decoder with valid/ready requests and a
// sweep mode that walks every select line once, one per cycle.
module reg_sel_decoder #(
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    input  logic              clr_start,
    output logic              busy,
    output logic [(1<<ADDR_W)-1:0] reg_no,
    output logic              reg_no_valid
);

    localparam int NREG  = 1 << ADDR_W;
    localparam int CNT_W = ADDR_W + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NREG-1:0]   reg_no_d;
    logic              reg_no_valid_d;

    // NOTE: every output of this block gets a default before the case so no
    // path through it leaves a variable unassigned, which would infer a latch.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        reg_no_d       = '0;
        reg_no_valid_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (clr_start) begin
                    state_d        = SWEEP;
                    reg_no_d       = NREG'(1);
                    reg_no_valid_d = 1'b1;
                    cnt_d          = CNT_W'(1);
                end else if (req_valid) begin
                    reg_no_d       = NREG'(1) << req_addr;
                    reg_no_valid_d = 1'b1;
                end
            end
            SWEEP: begin
                // cnt reaches NREG only after the last index has been issued
                if (cnt_q < CNT_W'(NREG)) begin
                    reg_no_d       = NREG'(1) << cnt_q[ADDR_W-1:0];
                    reg_no_valid_d = 1'b1;
                    cnt_d          = cnt_q + CNT_W'(1);
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            reg_no       <= '0;
            reg_no_valid <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            reg_no       <= reg_no_d;
            reg_no_valid <= reg_no_valid_d;
        end
    end

    assign busy      = (state_q == SWEEP);
    assign req_ready = !busy && !clr_start;

endmodule

// File: tb/tb_reg_sel_decoder.sv
// Drives ADDR_W=2 and ADDR_W=3 decoders with shared stimulus and compares both
// against an expected-output queue model, cycle by cycle.
module tb_reg_sel_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic [2:0] req_addr;
    logic       clr_start;

    logic       rdy2, busy2, v2;
    logic [3:0] reg2;
    logic       rdy3, busy3, v3;
    logic [7:0] reg3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    reg_sel_decoder #(.ADDR_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr[1:0]),
        .req_ready(rdy2), .clr_start(clr_start), .busy(busy2), .reg_no(reg2),
        .reg_no_valid(v2)
    );

    reg_sel_decoder #(.ADDR_W(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(rdy3), .clr_start(clr_start), .busy(busy3), .reg_no(reg3),
        .reg_no_valid(v3)
    );

    // Expected output for one cycle; a sweep is queued as its full output list.
    typedef struct packed {
        logic [7:0] reg_no;
        logic       valid;
        logic       busy;
    } exp_t;

    exp_t q   [2][$];
    exp_t cur [2];
    int   nreg [2] = '{4, 8};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            q[k].delete();
            cur[k] = '0;
        end
    endtask

    task automatic model_edge(input int k);
        exp_t e;
        if (q[k].size() == 0 && clr_start) begin
            for (int i = 0; i < nreg[k]; i++) begin
                e.reg_no = 8'(1) << i;
                e.valid  = 1'b1;
                e.busy   = 1'b1;
                q[k].push_back(e);
            end
            q[k].push_back('0);
        end
        if (q[k].size() != 0) begin
            cur[k] = q[k].pop_front();
        end else if (req_valid) begin
            e.reg_no = 8'(1) << (int'(req_addr) % nreg[k]);
            e.valid  = 1'b1;
            e.busy   = 1'b0;
            cur[k]   = e;
        end else begin
            cur[k] = '0;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".reg_no2"}, 32'(reg2), 32'(cur[0].reg_no));
        check({tag, ".valid2"},  32'(v2),   32'(cur[0].valid));
        check({tag, ".busy2"},   32'(busy2), 32'(cur[0].busy));
        check({tag, ".ready2"},  32'(rdy2), 32'(!cur[0].busy && !clr_start));
        check({tag, ".reg_no3"}, 32'(reg3), 32'(cur[1].reg_no));
        check({tag, ".valid3"},  32'(v3),   32'(cur[1].valid));
        check({tag, ".busy3"},   32'(busy3), 32'(cur[1].busy));
        check({tag, ".ready3"},  32'(rdy3), 32'(!cur[1].busy && !clr_start));
    endtask

    // One clock: model follows the edge, outputs are compared at the falling edge.
    task automatic step(input string tag);
        @(posedge clk);
        if (rst_n) begin
            model_edge(0);
            model_edge(1);
        end
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic async_reset(input string tag);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic req(input logic v, input logic [2:0] a, input logic c);
        req_valid = v;
        req_addr  = a;
        clr_start = c;
    endtask

    initial begin
        rst_n = 1'b0;
        req(1'b1, 3'd3, 1'b1);
        model_reset();
        #3;
        check_all("rst_hold");
        step("rst_hold_edge");
        step("rst_hold_edge2");
        clr_start = 1'b0;
        #1;
        check_all("rst_ready");
        @(negedge clk);
        rst_n = 1'b1;

        // Single decode of address 2, then idle.
        req(1'b1, 3'd2, 1'b0);
        step("single");
        req(1'b0, 3'd0, 1'b0);
        step("single_off");

        // Back-to-back requests.
        req(1'b1, 3'd0, 1'b0); step("b2b0");
        req(1'b1, 3'd1, 1'b0); step("b2b1");
        req(1'b1, 3'd3, 1'b0); step("b2b3");
        req(1'b1, 3'd2, 1'b0); step("b2b2");
        req(1'b1, 3'd7, 1'b0); step("b2b7");
        req(1'b0, 3'd0, 1'b0); step("b2b_end");

        // One-cycle sweep request, then let both sweeps drain.
        req(1'b0, 3'd0, 1'b1); step("sweep_start");
        clr_start = 1'b0;
        for (int i = 0; i < 11; i++) step("sweep");

        // Sweep start collides with a request that is then held.
        req(1'b1, 3'd3, 1'b1);
        #1;
        check_all("collide_ready");
        step("collide");
        clr_start = 1'b0;
        for (int i = 0; i < 12; i++) step("collide_hold");
        req(1'b0, 3'd0, 1'b0);
        step("collide_end");

        // Reset after index 1 of a sweep, then a fresh decode.
        req(1'b0, 3'd0, 1'b1); step("midrst_idx0");
        clr_start = 1'b0;
        step("midrst_idx1");
        async_reset("midrst_async");
        req(1'b1, 3'd2, 1'b0); step("post_rst_req");
        req(1'b0, 3'd0, 1'b0); step("post_rst_idle");

        // clr_start held high continuously.
        req(1'b0, 3'd0, 1'b1);
        for (int i = 0; i < 22; i++) step("clr_held");
        clr_start = 1'b0;
        for (int i = 0; i < 10; i++) step("clr_held_drain");

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            req(1'($urandom_range(0, 3) != 0), 3'($urandom), 1'($urandom_range(0, 15) == 0));
            if ($urandom_range(0, 99) == 0)
                async_reset("rand_rst");
            else
                step("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
